// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
//   Round-robin req/gnt/done arbiter sharing one synchronous RAM between the
//   instruction-fetch port (I, read-only) and the data port (D, read/write).
//   Rev 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_w_en,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic              last_is_d_q, last_is_d_d;
   logic              acc_we_q,    acc_we_d;
   logic              i_gnt_q,     i_gnt_d;
   logic              d_gnt_q,     d_gnt_d;
   logic              i_done_q,    i_done_d;
   logic              d_done_q,    d_done_d;
   logic [DATA_W-1:0] rdata_q,     rdata_d;
   logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
   logic              ram_w_en_q,  ram_w_en_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              pick_d;

   // On a tie the port that did not win last time goes first.
   assign pick_d = d_req & (~i_req | ~last_is_d_q);

   always_comb begin
      state_d     = state_q;
      last_is_d_d = last_is_d_q;
      acc_we_d    = acc_we_q;
      i_gnt_d     = 1'b0;
      d_gnt_d     = 1'b0;
      i_done_d    = 1'b0;
      d_done_d    = 1'b0;
      rdata_d     = rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_w_en_d  = 1'b0;
      ram_wdata_d = ram_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (i_req | d_req) begin
               if (pick_d) begin
                  ram_addr_d  = d_addr;
                  ram_wdata_d = d_wdata;
                  ram_w_en_d  = d_we;
                  acc_we_d    = d_we;
                  d_gnt_d     = 1'b1;
               end else begin
                  ram_addr_d  = i_addr;
                  acc_we_d    = 1'b0;
                  i_gnt_d     = 1'b1;
               end
               last_is_d_d = pick_d;
               state_d     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (acc_we_q) begin
               d_done_d = 1'b1;
            end else begin
               rdata_d  = ram_rdata;
               d_done_d = last_is_d_q;
               i_done_d = ~last_is_d_q;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         last_is_d_q <= 1'b1;
         acc_we_q    <= 1'b0;
         i_gnt_q     <= 1'b0;
         d_gnt_q     <= 1'b0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         rdata_q     <= '0;
         ram_addr_q  <= '0;
         ram_w_en_q  <= 1'b0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_is_d_q <= last_is_d_d;
         acc_we_q    <= acc_we_d;
         i_gnt_q     <= i_gnt_d;
         d_gnt_q     <= d_gnt_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         rdata_q     <= rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_w_en_q  <= ram_w_en_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign i_gnt     = i_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign i_done    = i_done_q;
   assign d_done    = d_done_q;
   assign rdata     = rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_w_en  = ram_w_en_q;
   assign ram_wdata = ram_wdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter
//   Randomised and directed bench with a transaction-level reference model.
//   Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req, d_we;
   logic [7:0]  i_addr, d_addr;
   logic [15:0] d_wdata;
   logic        i_gnt, i_done, d_gnt, d_done, ram_w_en, busy;
   logic [15:0] rdata, ram_wdata, ram_rdata;
   logic [7:0]  ram_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata),
      .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   function automatic logic [15:0] init_val(input logic [7:0] a);
      if (a == 8'h05) return 16'h1234;
      return 16'({8'h00, a} * 16'd40503) ^ 16'hA5A5;
   endfunction

   // Synchronous RAM environment: read data valid one cycle after address.
   logic [15:0] ram_mem [256];
   bit          ram_init = 1'b0;
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int k = 0; k < 256; k++) ram_mem[k] <= init_val(8'(k));
         ram_init <= 1'b1;
      end else if (ram_w_en) begin
         ram_mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= ram_mem[ram_addr];
   end

   // Reference model: each granted access is an event at edge acc_edge;
   // gnt follows that edge, the RAM write lands one edge later, done two later,
   // and the arbiter may accept again three edges later.
   logic [15:0] mdl_mem [256];
   bit          mdl_init = 1'b0;
   int          cur, acc_edge;
   bit          acc_is_d, acc_we, last_is_d;
   logic [7:0]  acc_addr;
   logic [15:0] acc_wdata, exp_rdata;
   wire         mdl_win_d = d_req && (!i_req || !last_is_d);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if (!mdl_init) begin
            for (int k = 0; k < 256; k++) mdl_mem[k] <= init_val(8'(k));
            mdl_init <= 1'b1;
         end
         cur       <= 0;
         acc_edge  <= -100;
         last_is_d <= 1'b1;
         acc_is_d  <= 1'b0;
         acc_we    <= 1'b0;
         exp_rdata <= '0;
      end else begin
         cur <= cur + 1;
         if (cur + 1 == acc_edge + 1 && acc_we) mdl_mem[acc_addr] <= acc_wdata;
         if (cur + 1 == acc_edge + 2 && !acc_we) exp_rdata <= mdl_mem[acc_addr];
         if (cur + 1 >= acc_edge + 3 && (i_req || d_req)) begin
            acc_edge  <= cur + 1;
            acc_is_d  <= mdl_win_d;
            acc_we    <= mdl_win_d && d_we;
            acc_addr  <= mdl_win_d ? d_addr : i_addr;
            acc_wdata <= d_wdata;
            last_is_d <= mdl_win_d;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check_eq("i_gnt",    i_gnt,    cur == acc_edge && !acc_is_d);
      check_eq("d_gnt",    d_gnt,    cur == acc_edge && acc_is_d);
      check_eq("i_done",   i_done,   cur == acc_edge + 2 && !acc_is_d);
      check_eq("d_done",   d_done,   cur == acc_edge + 2 && acc_is_d);
      check_eq("busy",     busy,     cur == acc_edge || cur == acc_edge + 1);
      check_eq("ram_w_en", ram_w_en, cur == acc_edge && acc_we);
      check_eq("rdata",    rdata,    exp_rdata);
      if (cur == acc_edge) check_eq("ram_addr", ram_addr, acc_addr);
      if (cur == acc_edge && acc_we) check_eq("ram_wdata", ram_wdata, acc_wdata);
   endtask

   bit hold = 1'b0;
   bit saw_i, saw_d;

   task automatic cycle();
      @(negedge clk);
      check_all();
      saw_i = i_gnt;
      saw_d = d_gnt;
      if (!hold) begin
         if (i_gnt) i_req = 1'b0;
         if (d_gnt) d_req = 1'b0;
      end
   endtask

   task automatic wait_gnt(input bit want_d, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         cycle();
         if (want_d ? saw_d : saw_i) seen = 1'b1;
      end
      check_eq(tag, seen, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [3:0] gnt_seq;
   int         gnt_cnt;

   initial begin
      i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
      do_reset();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_gnts", {i_gnt, d_gnt, i_done, d_done}, 0);
      check_eq("rst_ram_w_en", ram_w_en, 0);
      check_eq("rst_ram_addr", ram_addr, 0);
      check_eq("rst_ram_wdata", ram_wdata, 0);
      check_eq("rst_rdata", rdata, 0);

      // Fetch of address 5 straight out of reset.
      i_addr = 8'h05; i_req = 1'b1;
      cycle(); check_eq("t1_i_gnt_c1", i_gnt, 1); check_eq("t1_busy_c1", busy, 1);
      cycle(); check_eq("t1_busy_c2", busy, 1);
      cycle(); check_eq("t1_i_done_c3", i_done, 1); check_eq("t1_rdata", rdata, 16'h1234);
      check_eq("t1_busy_c3", busy, 0);

      // Data write then read-back.
      d_we = 1'b1; d_addr = 8'h10; d_wdata = 16'hBEEF; d_req = 1'b1;
      wait_gnt(1'b1, "t2_wr_gnt");
      check_eq("t2_w_en", ram_w_en, 1); check_eq("t2_addr", ram_addr, 8'h10);
      cycle(); check_eq("t2_w_en_drop", ram_w_en, 0);
      cycle(); check_eq("t2_d_done", d_done, 1);
      d_we = 1'b0; d_req = 1'b1;
      wait_gnt(1'b1, "t2_rd_gnt");
      cycle(); cycle(); check_eq("t2_readback", rdata, 16'hBEEF);

      // Both ports held high together from reset: I,D,I,D.
      do_reset();
      hold = 1'b1; gnt_seq = '0; gnt_cnt = 0;
      i_addr = 8'h03; d_addr = 8'h04; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cycle();
         check_eq("t3_one_gnt", i_gnt & d_gnt, 0);
         if (i_gnt || d_gnt) begin
            gnt_seq = {gnt_seq[2:0], d_gnt};
            gnt_cnt++;
         end
      end
      i_req = 1'b0; d_req = 1'b0; hold = 1'b0;
      check_eq("t3_gnt_cnt", gnt_cnt, 4);
      check_eq("t3_gnt_order", gnt_seq, 4'b0101);
      cycle();

      // Reset during the ACCESS cycle of a D write.
      d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'hCAFE; d_req = 1'b1;
      wait_gnt(1'b1, "t4_wr_gnt");
      #1 rst_n = 1'b0;
      #1 check_eq("t4_w_en_async", ram_w_en, 0); check_eq("t4_busy_async", busy, 0);
      cycle(); cycle();
      rst_n = 1'b1;
      d_we = 1'b0; i_addr = 8'h20; d_addr = 8'h21; i_req = 1'b1; d_req = 1'b1;
      wait_gnt(1'b0, "t4_first_gnt_i");
      check_eq("t4_no_d_gnt", d_gnt, 0);
      cycle(); cycle(); check_eq("t4_write_abandoned", rdata, init_val(8'h20));
      wait_gnt(1'b1, "t4_d_gnt");
      cycle(); cycle();

      // D request arriving during RESP of an I access.
      i_addr = 8'h05; i_req = 1'b1;
      wait_gnt(1'b0, "t5_i_gnt");
      cycle();
      d_we = 1'b0; d_addr = 8'h10; d_req = 1'b1;
      cycle(); check_eq("t5_no_early_dgnt", d_gnt, 0); check_eq("t5_i_done", i_done, 1);
      cycle(); check_eq("t5_d_gnt", d_gnt, 1); check_eq("t5_rdata_kept", rdata, 16'h1234);
      cycle(); cycle(); check_eq("t5_d_rdata", rdata, 16'hBEEF);

      // Random traffic on a small address window.
      for (int k = 0; k < 400; k++) begin
         cycle();
         if (!i_req && !saw_i && $urandom_range(0, 2) == 0) begin
            i_addr = 8'($urandom_range(0, 15));
            i_req  = 1'b1;
         end
         if (!d_req && !saw_d && $urandom_range(0, 2) == 0) begin
            d_addr  = 8'($urandom_range(0, 15));
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = 16'($urandom);
            d_req   = 1'b1;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (4) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
